// File: rtl/core_pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline registers: per-stage bus widths,
// the NOP control word, ID/EX bus field layout and the stage occupancy encoding.
package core_pipe_pkg;

    localparam int IFID_CTRL_W  = 24;
    localparam int IFID_DATA_W  = 96;
    localparam int IDEX_CTRL_W  = 24;
    localparam int IDEX_DATA_W  = 180;
    localparam int EXMEM_CTRL_W = 24;
    localparam int EXMEM_DATA_W = 140;
    localparam int MEMWB_CTRL_W = 24;
    localparam int MEMWB_DATA_W = 140;

    localparam logic [IDEX_CTRL_W-1:0] NOP_CTRL = '0;

    // ID/EX control bus field offsets (LSB positions)
    localparam int CTRL_BRANCH_LSB      = 0;   // 6 bits
    localparam int CTRL_JUMP_BIT        = 6;
    localparam int CTRL_REG_WRITE_BIT   = 7;
    localparam int CTRL_A_SRC_BIT       = 8;
    localparam int CTRL_B_SRC_BIT       = 9;
    localparam int CTRL_PC_TGT_SRC_BIT  = 10;
    localparam int CTRL_ALU_CTRL_LSB    = 11;  // 4 bits
    localparam int CTRL_MEM_WRITE_BIT   = 15;
    localparam int CTRL_RESULT_SRC_LSB  = 16;  // 2 bits
    localparam int CTRL_DQM_LSB         = 18;  // 2 bits
    localparam int CTRL_FUNCT3_LSB      = 20;  // 3 bits

    // ID/EX data bus field offsets (LSB positions)
    localparam int DATA_RS1_VAL_LSB = 0;    // 32 bits
    localparam int DATA_RS2_VAL_LSB = 32;   // 32 bits
    localparam int DATA_IMM_LSB     = 64;   // 32 bits
    localparam int DATA_PC_LSB      = 96;   // 32 bits
    localparam int DATA_PC4_LSB     = 128;  // 32 bits
    localparam int DATA_RD_LSB      = 160;  // 5 bits
    localparam int DATA_RS1_LSB     = 165;  // 5 bits
    localparam int DATA_RS2_LSB     = 170;  // 5 bits

    typedef struct packed {
        logic       spare;
        logic [2:0] funct3;
        logic [1:0] dqm;
        logic [1:0] result_src;
        logic       mem_write;
        logic [3:0] alu_control;
        logic       pc_target_src;
        logic       b_src;
        logic       a_src;
        logic       reg_write;
        logic       jump;
        logic [5:0] branch;
    } idex_ctrl_t;

    // Occupancy doubles as the FSM state so the state is always visible on the port.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    function automatic logic [IDEX_CTRL_W-1:0] pack_idex_ctrl(input idex_ctrl_t c);
        return c;
    endfunction

    function automatic logic [IDEX_DATA_W-1:0] pack_idex_data(
        input logic [31:0] rs1_val, input logic [31:0] rs2_val, input logic [31:0] imm,
        input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        logic [IDEX_DATA_W-1:0] d;
        d = '0;
        d[DATA_RS1_VAL_LSB +: 32] = rs1_val;
        d[DATA_RS2_VAL_LSB +: 32] = rs2_val;
        d[DATA_IMM_LSB     +: 32] = imm;
        d[DATA_PC_LSB      +: 32] = pc;
        d[DATA_PC4_LSB     +: 32] = pc + 32'd4;
        d[DATA_RD_LSB      +: 5]  = rd;
        d[DATA_RS1_LSB     +: 5]  = rs1;
        d[DATA_RS2_LSB     +: 5]  = rs2;
        return d;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid + control + data with load, drop and clear.
// Priority: rst > clear (flush) > load > drop; control is zero whenever valid is low.
module pipe_entry_reg
    import core_pipe_pkg::*;
#(
    parameter int CTRL_W     = 24,
    parameter int DATA_W     = 180,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (CLEAR_DATA != 0) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else if (drop) begin
            // data is left as-is; only the NOP control matters once invalid
            valid <= 1'b0;
            ctrl  <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush and optional 2-entry skid buffer.
// Handshake: a transfer happens on an edge where valid & ready are both high; valid never waits on ready.
module pipe_stage_hs
    import core_pipe_pkg::*;
#(
    parameter int CTRL_W     = 24,
    parameter int DATA_W     = 180,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_state_e state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       accept, consume;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              main_load, main_drop, main_from_skid;
    logic              skid_load, skid_drop;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;

    // With a skid entry, in_ready comes straight from a flop so out_ready never reaches upstream.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!main_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = state_q;

    assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_ld_data = main_from_skid ? skid_data : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_drop      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = OCC_MAIN;
                    end
                end
                OCC_MAIN: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        // only reachable with a skid entry; without one in_ready is low here
                        skid_load = 1'b1;
                        state_d   = OCC_FULL;
                    end else if (consume) begin
                        main_drop = 1'b1;
                        state_d   = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_drop      = 1'b1;
                        state_d        = OCC_MAIN;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (state_d != OCC_FULL);
    end

    pipe_entry_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .load    (main_load),
        .drop    (main_drop),
        .in_ctrl (main_ld_ctrl),
        .in_data (main_ld_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry_reg #(
            .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .clear   (flush),
            .load    (skid_load),
            .drop    (skid_drop),
            .in_ctrl (in_ctrl),
            .in_data (in_data),
            .valid   (skid_valid),
            .ctrl    (skid_ctrl),
            .data    (skid_data)
        );
    end else begin : g_no_skid
        assign skid_valid = 1'b0;
        assign skid_ctrl  = '0;
        assign skid_data  = '0;
    end

    a_occ_max: assert property (@(posedge clk) disable iff (rst) occupancy != 2'd3);
    a_main_consistent: assert property (@(posedge clk) disable iff (rst)
        main_valid == (state_q != OCC_EMPTY));
    a_skid_consistent: assert property (@(posedge clk) disable iff (rst)
        skid_valid == (state_q == OCC_FULL));

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: default build (a_*), SKID=0 build (b_*), CLEAR_DATA=0 build (c_*).
// Scoreboard queues model each stage's held entries; directed steps cover reset, stall, flush, streaming.
module tb_pipe_stage_hs;
    localparam int CW = 24;
    localparam int DW = 180;
    localparam int EW = CW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [1:0]    a_occ;
    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_occ;
    logic          c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [CW-1:0] c_in_ctrl, c_out_ctrl;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [1:0]    c_occ;

    logic [EW-1:0] a_exp_q[$];
    logic [EW-1:0] b_exp_q[$];
    int a_consumed = 0;
    int b_consumed = 0;
    int b_accepted = 0;

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ));

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ));

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(0)) dut_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ctrl(c_in_ctrl), .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occ));

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r[DW-1:0];
    endfunction

    // Scoreboard for the skid build: checks the held state, then applies the coming edge.
    always @(negedge clk) begin
        logic [EW-1:0] head;
        bit m_ready, m_consume, m_accept;
        if (mon_en) begin
            chk("a_occupancy", EW'(a_occ), EW'(a_exp_q.size()));
            chk("a_out_valid", EW'(a_out_valid), EW'(a_exp_q.size() != 0));
            chk("a_in_ready", EW'(a_in_ready), EW'(a_exp_q.size() != 2));
            if (a_exp_q.size() == 0) chk("a_nop_ctrl", EW'(a_out_ctrl), '0);
            else chk("a_head", {a_out_ctrl, a_out_data}, a_exp_q[0]);
            m_ready   = (a_exp_q.size() != 2);
            m_consume = (a_exp_q.size() != 0) && a_out_ready;
            m_accept  = a_in_valid && m_ready;
            if (!rst && m_consume) begin
                head = a_exp_q.pop_front();
                chk("a_order", {a_out_ctrl, a_out_data}, head);
                a_consumed++;
            end
            if (rst || a_flush) a_exp_q.delete();
            else if (m_accept) a_exp_q.push_back({a_in_ctrl, a_in_data});
        end
    end

    // Scoreboard for the single-entry build: in_ready is combinational on out_ready.
    always @(negedge clk) begin
        logic [EW-1:0] head;
        bit m_ready, m_consume, m_accept;
        if (mon_en) begin
            m_ready   = (b_exp_q.size() == 0) || b_out_ready;
            m_consume = (b_exp_q.size() != 0) && b_out_ready;
            m_accept  = b_in_valid && m_ready;
            chk("b_occupancy", EW'(b_occ), EW'(b_exp_q.size()));
            chk("b_out_valid", EW'(b_out_valid), EW'(b_exp_q.size() != 0));
            chk("b_in_ready", EW'(b_in_ready), EW'(m_ready));
            if (b_exp_q.size() == 0) chk("b_nop_ctrl", EW'(b_out_ctrl), '0);
            if (!rst && m_consume) begin
                head = b_exp_q.pop_front();
                chk("b_order", {b_out_ctrl, b_out_data}, head);
                b_consumed++;
            end
            if (rst || b_flush) b_exp_q.delete();
            else if (m_accept) begin
                b_exp_q.push_back({b_in_ctrl, b_in_data});
                b_accepted++;
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d_a, d_g;
        int cons0;
        a_flush = 0; a_in_valid = 0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 0;
        c_flush = 0; c_in_valid = 0; c_in_ctrl = '0; c_in_data = '0; c_out_ready = 0;

        // 1. reset, then pass-through
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        chk("t1_rst_out_valid", EW'(a_out_valid), '0);
        chk("t1_rst_out_ctrl", EW'(a_out_ctrl), '0);
        chk("t1_rst_out_data", EW'(a_out_data), '0);
        chk("t1_rst_occupancy", EW'(a_occ), '0);
        chk("t1_rst_in_ready", EW'(a_in_ready), EW'(1));
        rst = 1'b0;
        a_in_valid = 1; a_in_ctrl = 24'h00A5A5; a_in_data = 180'h1234; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        chk("t1_pass_valid", EW'(a_out_valid), EW'(1));
        chk("t1_pass_ctrl", EW'(a_out_ctrl), EW'(24'h00A5A5));
        chk("t1_pass_data", EW'(a_out_data), EW'(180'h1234));
        tick();

        // 2. back-pressure fill with A, B, C
        a_out_ready = 0;
        a_in_valid = 1; a_in_ctrl = 24'h0000A1; a_in_data = 180'hA;
        tick();
        a_in_ctrl = 24'h0000B2; a_in_data = 180'hB;
        tick();
        chk("t2_full_occ", EW'(a_occ), EW'(2));
        chk("t2_full_in_ready", EW'(a_in_ready), '0);
        a_in_ctrl = 24'h0000C3; a_in_data = 180'hC;
        tick();
        tick();
        chk("t2_stall_data", EW'(a_out_data), EW'(180'hA));
        chk("t2_stall_in_ready", EW'(a_in_ready), '0);
        a_out_ready = 1;
        tick();
        chk("t2_drain_b", {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, 24'h0000B2, 180'hB});
        tick();
        a_in_valid = 0;
        chk("t2_drain_c", {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, 24'h0000C3, 180'hC});
        tick();
        chk("t2_drained", EW'(a_out_valid), '0);

        // 3. flush in FULL, offered D discarded (dut_a clears data, dut_c holds it)
        a_out_ready = 0; c_out_ready = 0;
        d_a = rand_data(); d_g = rand_data();
        a_in_valid = 1; a_in_ctrl = 24'h0000E1; a_in_data = d_a;
        c_in_valid = 1; c_in_ctrl = 24'h0000F1; c_in_data = d_g;
        tick();
        a_in_ctrl = 24'h0000E2; a_in_data = rand_data();
        c_in_ctrl = 24'h0000F2; c_in_data = rand_data();
        tick();
        chk("t3_pre_occ_a", EW'(a_occ), EW'(2));
        chk("t3_pre_occ_c", EW'(c_occ), EW'(2));
        a_flush = 1; a_in_ctrl = 24'h0000DD; a_in_data = 180'hD;
        c_flush = 1; c_in_ctrl = 24'h0000DD; c_in_data = 180'hD;
        tick();
        a_flush = 0; a_in_valid = 0; c_flush = 0; c_in_valid = 0;
        chk("t3_a_flush_state", {a_out_valid, a_out_ctrl, a_occ}, '0);
        chk("t3_a_flush_data", EW'(a_out_data), '0);
        chk("t3_c_flush_state", {c_out_valid, c_out_ctrl, c_occ}, '0);
        chk("t3_c_flush_data_held", EW'(c_out_data), EW'(d_g));
        a_out_ready = 1; c_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_c_no_d", EW'(c_out_valid), '0);
        end

        // 4. streaming 100 random entries
        cons0 = a_consumed;
        for (int i = 0; i < 100; i++) begin
            a_in_valid = 1;
            a_in_ctrl = CW'($urandom_range(0, 32'h00FF_FFFF));
            a_in_data = rand_data();
            tick();
            chk("t4_occ_not_full", EW'(a_occ == 2'd2), '0);
        end
        a_in_valid = 0;
        tick();
        tick();
        chk("t4_stream_count", EW'(a_consumed - cons0), EW'(100));

        // 5. single-entry build, out_ready toggling
        b_in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            b_out_ready = i[0] ? 1'b0 : 1'b1;
            b_in_ctrl = CW'(b_accepted + 1);
            b_in_data = DW'(b_accepted) ^ rand_data();
            #1;
            chk("t5_in_ready_comb", EW'(b_in_ready),
                EW'((b_exp_q.size() == 0) || b_out_ready));
            tick();
        end
        b_in_valid = 0; b_out_ready = 1;
        tick();
        tick();
        chk("t5_no_loss", EW'(b_consumed), EW'(b_accepted));
        chk("t5_some_traffic", EW'(b_accepted >= 4), EW'(1));

        // 6. rst over flush (dut_c) and reset mid-FULL (dut_a)
        a_out_ready = 0; c_out_ready = 0;
        a_in_valid = 1; a_in_ctrl = 24'h000011; a_in_data = rand_data();
        c_in_valid = 1; c_in_ctrl = 24'h000022; c_in_data = rand_data();
        tick();
        a_in_ctrl = 24'h000033; a_in_data = rand_data();
        c_in_valid = 0;
        tick();
        a_in_valid = 0;
        chk("t6_pre_occ_a", EW'(a_occ), EW'(2));
        rst = 1; c_flush = 1;
        tick();
        rst = 0; c_flush = 0;
        chk("t6_c_data_zero", EW'(c_out_data), '0);
        chk("t6_c_state", {c_out_valid, c_out_ctrl, c_occ}, '0);
        chk("t6_a_state", {a_out_valid, a_out_ctrl, a_occ}, '0);
        chk("t6_a_data_zero", EW'(a_out_data), '0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
